// File: rtl/ps2_pkg.sv
// ps2_pkg : shared PS/2 state encoding, timing helpers and frame constants.  rev 1.0
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_WAIT_DEV  = 3'd3,
    ST_SHIFT     = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_FAIL      = 3'd6
  } ps2_state_t;

  localparam int         DEF_CLK_KHZ = 21400;
  localparam int         DEF_FILTER  = 8;
  localparam logic [3:0] PARITY_EDGE = 4'd9;
  localparam logic [3:0] STOP_EDGE   = 4'd10;
  localparam logic [3:0] ACK_EDGE    = 4'd11;

  // All timings are expressed in system clock cycles.
  function automatic int t_inh(input int khz);
    return khz / 10;
  endfunction

  function automatic int t_rts(input int khz);
    return (khz / 500 < 1) ? 1 : khz / 500;
  endfunction

  function automatic int t_first(input int khz);
    return khz * 15;
  endfunction

  function automatic int t_xfer(input int khz);
    return khz * 2;
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ps2_line_filter : 2-FF synchronizer, FILTER-sample debounce, falling-edge pulse.  rev 1.0
`default_nettype none

module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER = DEF_FILTER
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER) + 1;

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Idle PS/2 lines are pulled high, so the filter resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_fall <= 1'b0;
      if (r_sync[1] != r_level) begin
        if (r_cnt == CW'(FILTER - 1)) begin
          r_level <= r_sync[1];
          r_fall  <= r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ps2_host_tx : host-to-device PS/2 byte transmitter with request-to-send, odd parity and ACK check.  rev 1.0
`default_nettype none

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_KHZ = DEF_CLK_KHZ,
  parameter int FILTER  = DEF_FILTER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_strobe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic       o_rx_inhibit,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_dat_in,
  output logic       o_ps2_clk_out,
  output logic       o_ps2_dat_out
);

  localparam logic [19:0] c_T_INH   = 20'(t_inh(CLK_KHZ));
  localparam logic [19:0] c_T_RTS   = 20'(t_rts(CLK_KHZ));
  localparam logic [19:0] c_T_FIRST = 20'(t_first(CLK_KHZ));
  localparam logic [19:0] c_T_XFER  = 20'(t_xfer(CLK_KHZ));

  logic w_clk_f, w_fall, w_dat_f, w_dat_fall_unused;

  ps2_line_filter #(.FILTER(FILTER)) u_clk_filt (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (i_ps2_clk_in),
    .o_level (w_clk_f),
    .o_fall  (w_fall)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_dat_filt (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (i_ps2_dat_in),
    .o_level (w_dat_f),
    .o_fall  (w_dat_fall_unused)
  );

  ps2_state_t  r_state;
  logic [19:0] r_timer;
  logic [3:0]  r_cnt;
  logic [8:0]  r_shift;
  logic        r_busy, r_done, r_error, r_clk_out, r_dat_out;
  logic [3:0]  w_next_cnt;

  assign w_next_cnt = r_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_clk_out <= 1'b1;
      r_dat_out <= 1'b1;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // A strobe coinciding with the previous done/error pulse is dropped.
          if (i_strobe && !r_done && !r_error) begin
            r_shift   <= {odd_parity(i_data), i_data};
            r_busy    <= 1'b1;
            r_clk_out <= 1'b0;
            r_dat_out <= 1'b1;
            r_timer   <= '0;
            r_state   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (r_timer == c_T_INH - 20'd1) begin
            r_dat_out <= 1'b0;
            r_timer   <= '0;
            r_state   <= ST_RTS;
          end else begin
            r_timer <= r_timer + 20'd1;
          end
        end
        ST_RTS: begin
          if (r_timer == c_T_RTS - 20'd1) begin
            r_clk_out <= 1'b1;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_state   <= ST_WAIT_DEV;
          end else begin
            r_timer <= r_timer + 20'd1;
          end
        end
        ST_WAIT_DEV: begin
          if (w_fall) begin
            r_dat_out <= r_shift[0];
            r_shift   <= {1'b0, r_shift[8:1]};
            r_cnt     <= 4'd1;
            r_timer   <= '0;
            r_state   <= ST_SHIFT;
          end else if (r_timer == c_T_FIRST - 20'd1) begin
            r_state <= ST_FAIL;
          end else begin
            r_timer <= r_timer + 20'd1;
          end
        end
        ST_SHIFT: begin
          r_timer <= r_timer + 20'd1;
          if (w_fall) begin
            r_cnt <= w_next_cnt;
            if (w_next_cnt <= PARITY_EDGE) begin
              r_dat_out <= r_shift[0];
              r_shift   <= {1'b0, r_shift[8:1]};
            end else if (w_next_cnt == STOP_EDGE) begin
              r_dat_out <= 1'b1;
            end else begin
              r_state <= w_dat_f ? ST_FAIL : ST_WAIT_IDLE;
            end
          end else if (r_timer == c_T_XFER - 20'd1) begin
            r_state <= ST_FAIL;
          end
        end
        ST_WAIT_IDLE: begin
          if (w_clk_f && w_dat_f) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_timer <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (r_timer == c_T_XFER - 20'd1) begin
            r_state <= ST_FAIL;
          end else begin
            r_timer <= r_timer + 20'd1;
          end
        end
        ST_FAIL: begin
          r_clk_out <= 1'b1;
          r_dat_out <= 1'b1;
          r_error   <= 1'b1;
          r_busy    <= 1'b0;
          r_timer   <= '0;
          r_cnt     <= '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_rx_inhibit  = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_ps2_clk_out = r_clk_out;
  assign o_ps2_dat_out = r_dat_out;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx : vector table plus random bytes against a PS/2 device model and frame reference.  rev 1.0
`default_nettype none

module tb_ps2_host_tx;

  localparam int CLK_KHZ = 1000;
  localparam int FILTER  = 8;
  localparam int T_INH   = CLK_KHZ / 10;
  localparam int T_RTS   = CLK_KHZ / 500;
  localparam int T_FIRST = CLK_KHZ * 15;
  localparam int H       = 40;
  localparam int M_ACK = 0, M_NOACK = 1, M_SILENT = 2;
  localparam int NV = 14;

  logic       clk, rst, i_strobe;
  logic [7:0] i_data;
  logic       dev_clk, dev_dat, glitch;
  wire        o_busy, o_done, o_error, o_rx_inhibit, o_ps2_clk_out, o_ps2_dat_out;
  wire        pin_clk = o_ps2_clk_out & dev_clk & ~glitch;
  wire        pin_dat = o_ps2_dat_out & dev_dat;

  ps2_host_tx #(.CLK_KHZ(CLK_KHZ), .FILTER(FILTER)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_data        (i_data),
    .i_strobe      (i_strobe),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_rx_inhibit  (o_rx_inhibit),
    .i_ps2_clk_in  (pin_clk),
    .i_ps2_dat_in  (pin_dat),
    .o_ps2_clk_out (o_ps2_clk_out),
    .o_ps2_dat_out (o_ps2_dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, n_done = 0, n_err = 0, n_both = 0;
  int rel_cyc = 0, err_cyc = 0, low_run = 0, last_low = 0;
  logic prev_ck = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (o_done) n_done++;
    if (o_error) begin n_err++; err_cyc = cyc; end
    if (o_done && o_error) n_both++;
    if (o_busy && o_ps2_clk_out && !prev_ck) rel_cyc = cyc;
    prev_ck = o_ps2_clk_out;
    if (!o_ps2_clk_out) low_run++;
    else begin
      if (low_run != 0) last_low = low_run;
      low_run = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s got=%0d exp=[%0d..%0d]", name, got, lo, hi);
    end
  endtask

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference frame as the device sees it: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    i_data   = d;
    i_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_strobe = 1'b0;
    chk("lat_clk_low", o_ps2_clk_out, 0);
    chk("lat_busy", {o_busy, o_rx_inhibit}, 2'b11);
  endtask

  task automatic device(input int mode, input bit xs, input bit gl, input bit r5,
                        input logic [7:0] d, output logic [10:0] fr, output bit ok);
    fr = '1;
    ok = 1'b0;
    if (mode == M_SILENT) begin ok = 1'b1; return; end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pin_clk && !pin_dat) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    waitn(H);
    fr[0] = pin_dat;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      if (r5 && k == 5) begin
        waitn(H / 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_lines", {o_ps2_clk_out, o_ps2_dat_out}, 2'b11);
        chk("async_rst_busy", o_busy, 0);
        @(negedge clk);
        rst     = 1'b0;
        dev_clk = 1'b1;
        return;
      end
      if (xs && k == 2) begin
        i_data   = ~d;
        i_strobe = 1'b1;
        waitn(1);
        i_strobe = 1'b0;
        i_data   = d;
        waitn(H - 1);
      end else begin
        waitn(H);
      end
      fr[k]   = pin_dat;
      dev_clk = 1'b1;
      if (gl && k == 4) begin
        waitn(10);
        glitch = 1'b1;
        waitn(2);
        glitch = 1'b0;
        waitn(H - 12);
      end else begin
        waitn(H);
      end
    end
    dev_dat = (mode == M_ACK) ? 1'b0 : 1'b1;
    waitn(H / 2);
    dev_clk = 1'b0;
    waitn(H);
    dev_clk = 1'b1;
    waitn(H / 2);
    dev_dat = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         mode;
    bit         xs;
    bit         gl;
    bit         r5;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t        vt[NV];
  logic [10:0] fr;
  bit          ok;
  int          nd0, ne0;

  initial begin
    vt[0] = '{8'hED, M_ACK,    1'b0, 1'b0, 1'b0, 1, 0};
    vt[1] = '{8'h01, M_ACK,    1'b0, 1'b0, 1'b0, 1, 0};
    vt[2] = '{8'hA5, M_SILENT, 1'b0, 1'b0, 1'b0, 0, 1};
    vt[3] = '{8'h3C, M_NOACK,  1'b0, 1'b0, 1'b0, 0, 1};
    vt[4] = '{8'hFF, M_ACK,    1'b0, 1'b0, 1'b0, 1, 0};
    vt[5] = '{8'hF3, M_ACK,    1'b1, 1'b1, 1'b0, 1, 0};
    vt[6] = '{8'h55, M_ACK,    1'b0, 1'b0, 1'b1, 0, 0};
    vt[7] = '{8'h00, M_ACK,    1'b0, 1'b0, 1'b0, 1, 0};
    for (int i = 8; i < NV; i++) begin
      vt[i].data     = 8'($urandom_range(0, 255));
      vt[i].mode     = ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK;
      vt[i].xs       = 1'b0;
      vt[i].gl       = 1'b0;
      vt[i].r5       = 1'b0;
      vt[i].exp_done = (vt[i].mode == M_ACK) ? 1 : 0;
      vt[i].exp_err  = 1 - vt[i].exp_done;
    end

    rst = 1'b1; i_strobe = 1'b0; i_data = 8'h00;
    dev_clk = 1'b1; dev_dat = 1'b1; glitch = 1'b0;
    waitn(3);
    chk("reset_lines", {o_ps2_clk_out, o_ps2_dat_out}, 2'b11);
    chk("reset_flags", {o_busy, o_done, o_error, o_rx_inhibit}, 4'b0000);
    rst = 1'b0;
    waitn(20);
    chk("idle_lines", {o_ps2_clk_out, o_ps2_dat_out, o_busy}, 3'b110);

    for (int v = 0; v < NV; v++) begin
      nd0 = n_done;
      ne0 = n_err;
      send(vt[v].data);
      device(vt[v].mode, vt[v].xs, vt[v].gl, vt[v].r5, vt[v].data, fr, ok);
      chk("dev_request_seen", ok, 1);
      for (int i = 0; i < 20000 && o_busy; i++) @(negedge clk);
      chk("busy_end", o_busy, 0);
      waitn(5);
      chk("done_count", n_done - nd0, vt[v].exp_done);
      chk("error_count", n_err - ne0, vt[v].exp_err);
      chk("lines_released", {o_ps2_clk_out, o_ps2_dat_out}, 2'b11);
      if (!vt[v].r5)
        chk_rng("clk_low_cycles", last_low, T_INH + T_RTS, T_INH + T_RTS + 1);
      if (vt[v].mode != M_SILENT && !vt[v].r5)
        chk("frame", fr, ref_frame(vt[v].data));
      if (vt[v].mode == M_SILENT)
        chk_rng("first_edge_timeout", err_cyc - rel_cyc, T_FIRST - 2, T_FIRST + FILTER + 4);
      waitn(50);
    end

    chk("done_error_overlap", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: serializes one command byte (LED set 0xED, reset 0xFF, typematic 0xF3 and similar) onto the keyboard clock/data lines.
- Sits beside the PS/2 receive path on the ps2kCk/ps2kDQ open-drain pins.
- Implements the request-to-send sequence, device-clocked bit shifting, odd parity, stop bit and ACK check, with timeouts.

Parameters:
- CLK_KHZ, 21400, system clock frequency in kHz; all timing counts derive from it.
- FILTER, 8, consecutive equal samples required before a filtered PS/2 input changes.

Ports:
- clock  in  1  system clock (clk_sys)
- reset  in  1  asynchronous, active-high reset
- data  in  8  byte to send; sampled on the accepted strobe
- strobe  in  1  one-cycle send request; ignored while busy=1
- busy  out  1  high from the accepted strobe until done or error
- done  out  1  one-cycle pulse: byte sent and ACK received
- error  out  1  one-cycle pulse: timeout or missing ACK
- rx_inhibit  out  1  equals busy; the receive path ignores the bus while high
- ps2_clk_in  in  1  raw clock pin state
- ps2_dat_in  in  1  raw data pin state
- ps2_clk_out  out  1  0 drives the pin low, 1 releases it (Z)
- ps2_dat_out  out  1  0 drives the pin low, 1 releases it (Z)

Behaviour:
- Reset (async) and idle state: ps2_clk_out=1, ps2_dat_out=1, busy=0, done=0, error=0, state IDLE, all counters 0.
- Input conditioning: clk_in and dat_in each pass through a 2-FF synchronizer, then a FILTER-sample glitch filter. fall = filtered clock 1->0, registered as a one-cycle pulse.
- Timing constants:
  - T_INH = CLK_KHZ/10 cycles (100 us)
  - T_RTS = CLK_KHZ/500 cycles (2 us)
  - T_FIRST = CLK_KHZ*15 cycles (15 ms)
  - T_XFER = CLK_KHZ*2 cycles (2 ms)
  - A 20-bit timer holds all of them.
- Parity: odd, so parity bit = ~^data. A 9-bit shift register is loaded with {parity,data} on accept. 4-bit edge counter.
- States:
  - IDLE:
    - On strobe: latch the byte, busy<=1, clk_out<=0, timer<=0, go to INHIBIT.
    - strobe and reset asserted together: reset wins.
  - INHIBIT:
    - Hold clk_out=0, dat_out=1 for T_INH cycles.
    - Then dat_out<=0 (start bit), go to RTS.
  - RTS:
    - Hold clk low and data low for T_RTS cycles.
    - Then clk_out<=1, timer<=0, edge count<=0, go to WAIT_DEV.
  - WAIT_DEV:
    - On the first fall: drive dat_out=shift[0] (d0), shift right, count=1, go to SHIFT.
    - Timer reaches T_FIRST: go to FAIL.
  - SHIFT (timer keeps running from the first edge):
    - Falls 2..8 drive d1..d7.
    - Fall 9 drives parity.
    - Fall 10 releases data (stop bit, dat_out=1).
    - Fall 11: sample filtered data. 0 -> go to WAIT_IDLE. 1 -> go to FAIL (no ACK).
    - Timer reaches T_XFER before fall 11: go to FAIL.
  - WAIT_IDLE:
    - When filtered clk=1 and data=1 (device released ACK): done<=1 for one cycle, busy<=0, go to IDLE.
    - Timer reaches T_XFER here: go to FAIL.
  - FAIL:
    - Release both lines, error<=1 for one cycle, busy<=0, go to IDLE.
- Data changes only in the cycle after a falling edge, so data is stable while the device samples on the rising edge.
- Output latency: the first pin action (clk_out=0) appears the cycle after the accepted strobe. done or error is asserted exactly once per accepted strobe.
- done and error are never asserted in the same cycle.
- A strobe in the same cycle as done or error is ignored; a new strobe is accepted in IDLE only.
- Falling edges seen in INHIBIT or RTS (device still clocking out a byte) are ignored. The forced clock-low aborts that device transfer, per protocol.
- Asserting reset mid-transfer releases both lines asynchronously. No done or error pulse is generated.

Decomposition:
- ps2_pkg holds:
  - state encoding (IDLE, INHIBIT, RTS, WAIT_DEV, SHIFT, WAIT_IDLE, FAIL)
  - timing constant functions of CLK_KHZ
  - ACK edge index (11)
- Sub-module ps2_line_filter (synchronizer, FILTER debounce, falling-edge pulse) is instantiated for clock and data. The same sub-module is reused by the receive path.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz and ACKs -> clk held low >=2140 cycles; bits on device rising edges are 0,1,0,1,1,0,1,1,1,1(parity),1(stop); one done pulse; busy low after.
- Send 0x01 -> parity bit 0; frame 0,1,0,0,0,0,0,0,0,0,1; done pulse.
- Device model never clocks -> error pulse at 321000 (+/-filter latency) cycles after RTS release; both lines released; no done pulse.
- Device model clocks 11 edges but leaves data high on edge 11 -> error pulse, no done pulse; following strobe with 0xFF completes with done.
- Second strobe during busy, plus a 2-cycle glitch on clk_in during SHIFT -> second strobe ignored; glitch causes no bit advance; frame correct.
- Reset asserted at edge 5 of SHIFT -> clk_out=dat_out=1 and busy=0 immediately (asynchronous); no done or error; next strobe behaves normally.
